// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: request ops, access sizes,
// controller states and the alignment rule applied at request accept.
package lsu_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_LL    = 2'd2,
    OP_SC    = 2'd3
  } lsu_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } lsu_size_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } lsu_state_e;

  // LL/SC are always word accesses; the reserved size is never legal.
  function automatic logic misaligned(lsu_op_e op, lsu_size_e size, logic [1:0] lo);
    if (size == SZ_RSVD)                 return 1'b1;
    if (op == OP_LL || op == OP_SC)      return lo != 2'b00;
    if (size == SZ_HALF)                 return lo[0];
    if (size == SZ_WORD)                 return lo != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU-side request/response channel of the load/store unit.
interface lsu_if;
  import lsu_pkg::*;

  logic        req_valid;
  logic        req_ready;
  lsu_op_e     req_op;
  lsu_size_e   req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_op, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_align.sv
// Little-endian lane extraction with sign/zero extension for loads, and
// lane merge of store data into the read word for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic        is_signed,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed lane(s) and build both load and merged-store words.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can leave it unassigned (latch).
    byte_v     = rdata[{lane, 3'b000} +: 8];
    half_v     = rdata[{lane[1], 4'b0000} +: 16];
    load_data  = rdata;
    store_data = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{is_signed & byte_v[7]}}, byte_v};
        store_data = rdata;
        store_data[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data  = {{16{is_signed & half_v[15]}}, half_v};
        store_data = rdata;
        store_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request in flight, read-modify-write for
// sub-word stores, and a single LL/SC reservation register.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 6
) (
  input  logic              Clk,
  input  logic              Reset,
  lsu_if.slave              cpu,
  output logic              mem_re,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [MEM_AW+1:0] addr_q;
  lsu_op_e           op_q;
  lsu_size_e         size_q;
  logic              signed_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              link_valid;
  logic [MEM_AW-1:0] link_addr;

  logic              accept;
  logic              req_mis;
  logic              sc_hit;
  logic [MEM_AW-1:0] req_word;
  logic [MEM_AW-1:0] word_q;
  logic [31:0]       load_data;
  logic [31:0]       store_data;

  assign accept   = (state_q == S_IDLE) && cpu.req_valid;
  assign req_word = cpu.req_addr[MEM_AW+1:2];
  assign req_mis  = misaligned(cpu.req_op, cpu.req_size, cpu.req_addr[1:0]);
  assign sc_hit   = link_valid && (link_addr == req_word);
  assign word_q   = addr_q[MEM_AW+1:2];

  assign cpu.req_ready  = (state_q == S_IDLE);
  assign cpu.resp_valid = (state_q == S_RESP);
  assign cpu.resp_rdata = rdata_q;
  assign cpu.resp_err   = err_q;
  assign mem_re         = (state_q == S_READ);
  assign mem_we         = (state_q == S_WRITE);
  assign mem_addr       = word_q;
  assign mem_wdata      = wdata_q;

  lsu_align u_align (
    .size       (size_q),
    .is_signed  (signed_q),
    .lane       (addr_q[1:0]),
    .rdata      (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // State register; Reset aborts whatever access is in progress.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state selection by op, size and alignment of the accepted request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_mis) state_d = S_RESP;
          else begin
            case (cpu.req_op)
              OP_STORE: state_d = (cpu.req_size == SZ_WORD) ? S_WRITE : S_READ;
              OP_SC:    state_d = sc_hit ? S_WRITE : S_RESP;
              default:  state_d = S_READ;
            endcase
          end
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  state_d = (op_q == OP_STORE) ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (cpu.resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, load result / store merge, and reservation tracking.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_q     <= '0;
      op_q       <= OP_LOAD;
      size_q     <= SZ_BYTE;
      signed_q   <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else begin
      if (accept) begin
        addr_q   <= cpu.req_addr[MEM_AW+1:0];
        op_q     <= cpu.req_op;
        size_q   <= (cpu.req_op == OP_LL || cpu.req_op == OP_SC) ? SZ_WORD : cpu.req_size;
        signed_q <= cpu.req_signed;
        wdata_q  <= cpu.req_wdata;
        err_q    <= req_mis;
        rdata_q  <= {31'd0, (cpu.req_op == OP_SC) && sc_hit && !req_mis};
        if (cpu.req_op == OP_SC) link_valid <= 1'b0;
      end
      if (state_q == S_WAIT) begin
        if (op_q == OP_STORE) wdata_q <= store_data;
        else                  rdata_q <= load_data;
        if (op_q == OP_LL) begin
          link_valid <= 1'b1;
          link_addr  <= word_q;
        end
      end
      if (state_q == S_WRITE && op_q == OP_STORE && word_q == link_addr)
        link_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: word-addressed memory model with one-cycle
// read latency, strobe monitors and hand-computed expected responses.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        Clk;
  logic        Reset;
  logic        mem_re, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [0:63];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_acc = 0;
  int re_cnt = 0, we_cnt = 0, we_cyc = 0;
  logic [5:0]  we_addr;
  logic [31:0] we_data;

  lsu_if bus ();

  lsu_ctrl #(.MEM_AW(6)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .cpu       (bus),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(negedge Clk) begin
    if (mem_re) re_cnt++;
    if (mem_we) begin
      we_cnt++;
      we_cyc  = cyc;
      we_addr = mem_addr;
      we_data = mem_wdata;
    end
    assert (!(mem_re && mem_we))
      else begin
        errors++;
        $error("FAIL re_we_overlap: observed re=%b we=%b required not both", mem_re, mem_we);
      end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
  endtask

  task automatic send(input lsu_op_e op, input lsu_size_e sz, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wd);
    bus.req_op     = op;
    bus.req_size   = sz;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    @(negedge Clk);
    t_acc = cyc;
    @(posedge Clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Issue one request and wait (bounded) for its response; lat is cycles after accept.
  task automatic txn(input lsu_op_e op, input lsu_size_e sz, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd, output logic er,
                     output logic rdy_in_resp);
    lat = 99; rd = 'x; er = 'x; rdy_in_resp = 'x;
    send(op, sz, sgn, addr, wd);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (bus.resp_valid) begin
        lat = cyc - t_acc;
        rd  = bus.resp_rdata;
        er  = bus.resp_err;
        rdy_in_resp = bus.req_ready;
        break;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  int          lat, re0, we0;
  logic [31:0] rd, held;
  logic        er, rdy;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[3] = 32'h8899AABB;
    Reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = OP_LOAD; bus.req_size = SZ_BYTE;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b1;
    @(negedge Clk);
    check("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata,          32'd0);
    check("rst_resp_err",   {31'd0, bus.resp_err},   32'd0);
    check("rst_mem_re",     {31'd0, mem_re},         32'd0);
    check("rst_mem_we",     {31'd0, mem_we},         32'd0);
    check("rst_mem_addr",   {26'd0, mem_addr},       32'd0);
    check("rst_mem_wdata",  mem_wdata,               32'd0);
    @(posedge Clk); #1 Reset = 1'b0;
    @(posedge Clk); #1;

    // Signed byte load, lane 1 of 0x8899AABB.
    re0 = re_cnt; we0 = we_cnt;
    txn(OP_LOAD, SZ_BYTE, 1'b1, 32'h0D, 32'h0, lat, rd, er, rdy);
    check("ldb_s_lat",   lat, 32'd3);
    check("ldb_s_data",  rd,  32'hFFFFFFAA);
    check("ldb_s_err",   {31'd0, er}, 32'd0);
    check("ldb_s_re",    re_cnt - re0, 32'd1);
    check("ldb_s_we",    we_cnt - we0, 32'd0);
    check("resp_no_rdy", {31'd0, rdy}, 32'd0);

    txn(OP_LOAD, SZ_BYTE, 1'b0, 32'h0D, 32'h0, lat, rd, er, rdy);
    check("ldb_u_data",  rd, 32'h000000AA);
    txn(OP_LOAD, SZ_HALF, 1'b1, 32'h0E, 32'h0, lat, rd, er, rdy);
    check("ldh_s_data",  rd, 32'hFFFF8899);
    txn(OP_LOAD, SZ_WORD, 1'b1, 32'h0C, 32'h0, lat, rd, er, rdy);
    check("ldw_data",    rd, 32'h8899AABB);

    // Half store read-modify-write into upper lane of word 3.
    we0 = we_cnt;
    txn(OP_STORE, SZ_HALF, 1'b0, 32'h0E, 32'h00001234, lat, rd, er, rdy);
    check("sth_lat",     lat, 32'd4);
    check("sth_we_cnt",  we_cnt - we0, 32'd1);
    check("sth_we_cyc",  we_cyc - t_acc, 32'd3);
    check("sth_wdata",   we_data, 32'h1234AABB);
    check("sth_waddr",   {26'd0, we_addr}, 32'd3);
    check("sth_rdata",   rd, 32'd0);
    txn(OP_LOAD, SZ_WORD, 1'b0, 32'h0C, 32'h0, lat, rd, er, rdy);
    check("sth_readback", rd, 32'h1234AABB);

    // Misaligned and reserved-size requests.
    re0 = re_cnt; we0 = we_cnt;
    txn(OP_LOAD, SZ_WORD, 1'b0, 32'h06, 32'h0, lat, rd, er, rdy);
    check("mis_w_lat",   lat, 32'd1);
    check("mis_w_err",   {31'd0, er}, 32'd1);
    check("mis_w_rdata", rd, 32'd0);
    txn(OP_LOAD, SZ_RSVD, 1'b0, 32'h00, 32'h0, lat, rd, er, rdy);
    check("rsvd_err",    {31'd0, er}, 32'd1);
    txn(OP_STORE, SZ_HALF, 1'b0, 32'h01, 32'hFFFF, lat, rd, er, rdy);
    check("mis_h_err",   {31'd0, er}, 32'd1);
    check("mis_no_re",   re_cnt - re0, 32'd0);
    check("mis_no_we",   we_cnt - we0, 32'd0);

    // Word store, then a load through a wrapped high address.
    we0 = we_cnt;
    txn(OP_STORE, SZ_WORD, 1'b0, 32'h20, 32'hDEADBEEF, lat, rd, er, rdy);
    check("stw_lat",     lat, 32'd2);
    check("stw_we_cnt",  we_cnt - we0, 32'd1);
    check("stw_waddr",   {26'd0, we_addr}, 32'd8);
    txn(OP_LOAD, SZ_WORD, 1'b0, 32'h120, 32'h0, lat, rd, er, rdy);
    check("wrap_data",   rd, 32'hDEADBEEF);

    // LL/SC success, then a repeated SC that must fail.
    txn(OP_LL, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, rd, er, rdy);
    check("ll_lat",      lat, 32'd3);
    check("ll_data",     rd, 32'd0);
    we0 = we_cnt;
    txn(OP_SC, SZ_WORD, 1'b0, 32'h10, 32'd5, lat, rd, er, rdy);
    check("sc1_lat",     lat, 32'd2);
    check("sc1_rdata",   rd, 32'd1);
    check("sc1_we",      we_cnt - we0, 32'd1);
    check("sc1_mem4",    mem[4], 32'd5);
    we0 = we_cnt;
    txn(OP_SC, SZ_WORD, 1'b0, 32'h10, 32'd9, lat, rd, er, rdy);
    check("sc2_rdata",   rd, 32'd0);
    check("sc2_we",      we_cnt - we0, 32'd0);

    // An intervening byte store to the linked word breaks the reservation.
    txn(OP_LL, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, rd, er, rdy);
    check("ll2_data",    rd, 32'd5);
    txn(OP_STORE, SZ_BYTE, 1'b0, 32'h11, 32'h000000EE, lat, rd, er, rdy);
    check("stb_mem4",    mem[4], 32'h0000EE05);
    we0 = we_cnt;
    txn(OP_SC, SZ_WORD, 1'b0, 32'h10, 32'h77, lat, rd, er, rdy);
    check("sc3_rdata",   rd, 32'd0);
    check("sc3_we",      we_cnt - we0, 32'd0);
    check("sc3_mem4",    mem[4], 32'h0000EE05);

    // Reset in WAIT of a byte store with a live reservation.
    txn(OP_LL, SZ_WORD, 1'b0, 32'h20, 32'h0, lat, rd, er, rdy);
    we0 = we_cnt;
    send(OP_STORE, SZ_BYTE, 1'b0, 32'h30, 32'h55);
    @(posedge Clk); #1 Reset = 1'b1;
    @(negedge Clk);
    check("ar_req_ready",  {31'd0, bus.req_ready},  32'd1);
    check("ar_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("ar_resp_rdata", bus.resp_rdata,          32'd0);
    check("ar_resp_err",   {31'd0, bus.resp_err},   32'd0);
    check("ar_mem_re",     {31'd0, mem_re},         32'd0);
    check("ar_mem_addr",   {26'd0, mem_addr},       32'd0);
    check("ar_mem_wdata",  mem_wdata,               32'd0);
    check("ar_link_valid", {31'd0, dut.link_valid}, 32'd0);
    @(posedge Clk); #1 Reset = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    check("ar_no_we",      we_cnt - we0, 32'd0);
    check("ar_mem12",      mem[12], 32'd0);

    // Response held stable while resp_ready is low.
    bus.resp_ready = 1'b0;
    send(OP_LOAD, SZ_WORD, 1'b0, 32'h0C, 32'h0);
    lat = 99;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (bus.resp_valid) begin
        lat = cyc - t_acc;
        break;
      end
    end
    check("hold_lat",      lat, 32'd3);
    held = bus.resp_rdata;
    check("hold_first",    held, 32'h1234AABB);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("hold_valid",  {31'd0, bus.resp_valid}, 32'd1);
      check("hold_rdata",  bus.resp_rdata, 32'h1234AABB);
    end
    @(posedge Clk); #1 bus.resp_ready = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk);
    check("rel_valid",     {31'd0, bus.resp_valid}, 32'd0);
    check("rel_ready",     {31'd0, bus.req_ready},  32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
